// File: rtl/lebug_pkg.sv
// Shared types and defaults for the input buffer pointer/occupancy control.
// The typedefs describe the default buffer geometry used across the block.
package lebug_pkg;

   localparam int IB_DEPTH_DEFAULT    = 4;
   localparam int RAM_LATENCY_DEFAULT = 1;

   typedef logic [$clog2(IB_DEPTH_DEFAULT)-1:0]   ib_addr_t;
   typedef logic [$clog2(IB_DEPTH_DEFAULT+1)-1:0] ib_occ_t;

endpackage

// File: rtl/valid_delay_line.sv
// N-stage shift register with synchronous reset; carries {valid, eof} from the
// read-accept cycle to the cycle the RAM read data appears.
module valid_delay_line #(
   parameter int STAGES = 2,
   parameter int W      = 2
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] stage [STAGES];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < STAGES; i++) stage[i] <= '0;
      end else begin
         stage[0] <= d;
         for (int i = 1; i < STAGES; i++) stage[i] <= stage[i-1];
      end
   end

   assign q = stage[STAGES-1];

endmodule

// File: rtl/input_buffer_ctrl.sv
// FIFO pointer/occupancy controller for the input buffer's dual-port vector RAM.
// Port A writes at wr_ptr, port B reads at rd_ptr; EOF tags are kept per slot.
module input_buffer_ctrl
   import lebug_pkg::*;
#(
   parameter int IB_DEPTH    = IB_DEPTH_DEFAULT,
   parameter int RAM_LATENCY = RAM_LATENCY_DEFAULT,
   localparam int OCC_W      = $clog2(IB_DEPTH+1),
   localparam int AW         = $clog2(IB_DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             enqueue,
   input  logic             eof_in,
   input  logic             dequeue,
   output logic [AW-1:0]    mem_address_a,
   output logic             mem_wren_a,
   output logic [AW-1:0]    mem_address_b,
   output logic             valid_out,
   output logic             eof_out,
   output logic             full,
   output logic             empty,
   output logic [OCC_W-1:0] occupancy,
   output logic             overflow
);

   localparam logic [OCC_W-1:0] OCC_ONE  = OCC_W'(1);
   localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(IB_DEPTH);
   localparam logic [AW-1:0]    AW_ONE   = AW'(1);

   logic [AW-1:0]       wr_ptr;
   logic [AW-1:0]       rd_ptr;
   logic [IB_DEPTH-1:0] eof_slot;
   logic                wr_acc;
   logic                rd_acc;
   logic [OCC_W-1:0]    occ_next;
   logic [1:0]          dl_in;
   logic [1:0]          dl_out;

   // A write into a full buffer is accepted when a read frees a slot the same cycle.
   always_comb begin
      wr_acc   = enqueue & (~full | dequeue);
      rd_acc   = dequeue & ~empty;
      occ_next = occupancy;
      if (wr_acc && !rd_acc)
         occ_next = occupancy + OCC_ONE;
      else if (!wr_acc && rd_acc)
         occ_next = occupancy - OCC_ONE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         eof_slot      <= '0;
         occupancy     <= '0;
         mem_address_a <= '0;
         mem_address_b <= '0;
         mem_wren_a    <= 1'b0;
         full          <= 1'b0;
         empty         <= 1'b1;
         overflow      <= 1'b0;
      end else begin
         mem_wren_a <= wr_acc;
         if (wr_acc) begin
            mem_address_a    <= wr_ptr;
            eof_slot[wr_ptr] <= eof_in;
            wr_ptr           <= wr_ptr + AW_ONE;
         end
         if (rd_acc) begin
            mem_address_b <= rd_ptr;
            rd_ptr        <= rd_ptr + AW_ONE;
         end
         // Flags come from the next occupancy so empty drops only once the write commits.
         occupancy <= occ_next;
         full      <= (occ_next == OCC_FULL);
         empty     <= (occ_next == '0);
         if (enqueue && full && !dequeue)
            overflow <= 1'b1;
      end
   end

   // The EOF tag is read from the slot before any same-cycle write to it lands.
   assign dl_in = {rd_acc, rd_acc & eof_slot[rd_ptr]};

   valid_delay_line #(
      .STAGES (1 + RAM_LATENCY),
      .W      (2)
   ) u_valid_delay_line (
      .clk (clk),
      .rst (rst),
      .d   (dl_in),
      .q   (dl_out)
   );

   assign valid_out = dl_out[1];
   assign eof_out   = dl_out[0];

endmodule
